cfu_mac_sequencer: RTL and testbench

Initiator for the CFU command/response interface: drives the `cmd_*` / `rsp_*` handshake from the CPU side so a dot product over packed int8 operand buffers runs without per-word CPU involvement. On `start` it issues SET_OFFSET, then RESET, then one MAC command per 32-bit word pair fetched from two operand memories. It returns the final 32-bit accumulator on `result` with a one-cycle `done` pulse. It sits between a host control register block and the CFU.

---
 rtl/cfu_pkg.sv | 32 +++
 rtl/cfu_mac_sequencer.sv | 165 ++++++++++++++++
 tb/tb_cfu_mac_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfu_pkg.sv
// Shared CFU command encoding and sequencer state type.
// Responders and the sequencer both build function_id from these constants.
package cfu_pkg;

  localparam logic [6:0] F7_ADD        = 7'd0;
  localparam logic [6:0] F7_RESET      = 7'd1;
  localparam logic [6:0] F7_SET_OFFSET = 7'd2;
  localparam logic [6:0] F7_FULLY      = 7'd3;
  localparam logic [2:0] FUNCT3        = 3'd0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG_CMD,
    ST_CFG_RSP,
    ST_CLR_CMD,
    ST_CLR_RSP,
    ST_RD,
    ST_CAP,
    ST_MAC_CMD,
    ST_MAC_RSP,
    ST_DONE
  } state_t;

  function automatic logic [9:0] pack_function_id(input logic [6:0] f7);
    return {f7, FUNCT3};
  endfunction

  function automatic logic [31:0] sext9(input logic [8:0] v);
    return {{23{v[8]}}, v};
  endfunction

endpackage

// File: rtl/cfu_mac_sequencer.sv
// CFU initiator: SET_OFFSET, RESET, then one MAC per fetched operand word pair.
// At most one command outstanding; result and a done pulse at the end of each run.
module cfu_mac_sequencer
  import cfu_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] act_base,
  input  logic [ADDR_W-1:0] wgt_base,
  input  logic [8:0]        input_offset,
  input  logic [8:0]        filter_offset,
  input  logic              fully,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] act_addr,
  output logic [ADDR_W-1:0] wgt_addr,
  input  logic [31:0]       act_rdata,
  input  logic [31:0]       wgt_rdata,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [9:0]        cmd_payload_function_id,
  output logic [31:0]       cmd_payload_inputs_0,
  output logic [31:0]       cmd_payload_inputs_1,
  input  logic              rsp_valid,
  output logic              rsp_ready,
  input  logic [31:0]       rsp_payload_outputs_0,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result
);

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx;
  logic [LEN_W-1:0]  next_idx;
  logic              last_word;
  logic [ADDR_W-1:0] act_base_q;
  logic [ADDR_W-1:0] wgt_base_q;
  logic              fully_q;

  assign next_idx  = idx + LEN_W'(1);
  assign last_word = (idx == len_q - LEN_W'(1));

  assign busy      = (state != ST_IDLE);
  assign rsp_ready = (state == ST_CFG_RSP) || (state == ST_CLR_RSP) ||
                     (state == ST_MAC_RSP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                   <= ST_IDLE;
      len_q                   <= '0;
      idx                     <= '0;
      act_base_q              <= '0;
      wgt_base_q              <= '0;
      fully_q                 <= 1'b0;
      mem_rd_en               <= 1'b0;
      act_addr                <= '0;
      wgt_addr                <= '0;
      cmd_valid               <= 1'b0;
      cmd_payload_function_id <= '0;
      cmd_payload_inputs_0    <= '0;
      cmd_payload_inputs_1    <= '0;
      done                    <= 1'b0;
      result                  <= '0;
    end else begin
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q                   <= len;
            act_base_q              <= act_base;
            wgt_base_q              <= wgt_base;
            fully_q                 <= fully;
            idx                     <= '0;
            cmd_valid               <= 1'b1;
            cmd_payload_function_id <= pack_function_id(F7_SET_OFFSET);
            cmd_payload_inputs_0    <= sext9(input_offset);
            cmd_payload_inputs_1    <= sext9(filter_offset);
            state                   <= ST_CFG_CMD;
          end
        end
        ST_CFG_CMD: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= ST_CFG_RSP;
          end
        end
        ST_CFG_RSP: begin
          if (rsp_valid) begin
            cmd_valid               <= 1'b1;
            cmd_payload_function_id <= pack_function_id(F7_RESET);
            cmd_payload_inputs_0    <= '0;
            cmd_payload_inputs_1    <= '0;
            state                   <= ST_CLR_CMD;
          end
        end
        ST_CLR_CMD: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= ST_CLR_RSP;
          end
        end
        ST_CLR_RSP: begin
          if (rsp_valid) begin
            result <= rsp_payload_outputs_0;
            if (len_q == '0) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              mem_rd_en <= 1'b1;
              act_addr  <= act_base_q;
              wgt_addr  <= wgt_base_q;
              state     <= ST_RD;
            end
          end
        end
        ST_RD: begin
          state <= ST_CAP;
        end
        // Read data lands this cycle; it goes straight into the held payload.
        ST_CAP: begin
          cmd_valid               <= 1'b1;
          cmd_payload_function_id <= pack_function_id(fully_q ? F7_FULLY : F7_ADD);
          cmd_payload_inputs_0    <= act_rdata;
          cmd_payload_inputs_1    <= wgt_rdata;
          state                   <= ST_MAC_CMD;
        end
        ST_MAC_CMD: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= ST_MAC_RSP;
          end
        end
        ST_MAC_RSP: begin
          if (rsp_valid) begin
            result <= rsp_payload_outputs_0;
            if (last_word) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              idx       <= next_idx;
              mem_rd_en <= 1'b1;
              // Buffer addresses wrap modulo 2^ADDR_W.
              act_addr  <= act_base_q + next_idx[ADDR_W-1:0];
              wgt_addr  <= wgt_base_q + next_idx[ADDR_W-1:0];
              state     <= ST_RD;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfu_mac_sequencer.sv
// Bench for cfu_mac_sequencer: CFU responder model, operand memories,
// expectation queues filled at stimulus time and drained by a monitor.
module tb_cfu_mac_sequencer;

  localparam int ADDR_W = 10;
  localparam int LEN_W  = 11;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] act_base, wgt_base;
  logic [8:0]        input_offset, filter_offset;
  logic              fully;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] act_addr, wgt_addr;
  logic [31:0]       act_rdata, wgt_rdata;
  logic              cmd_valid, cmd_ready;
  logic [9:0]        cmd_payload_function_id;
  logic [31:0]       cmd_payload_inputs_0, cmd_payload_inputs_1;
  logic              rsp_valid, rsp_ready;
  logic [31:0]       rsp_payload_outputs_0;
  logic              busy, done;
  logic [31:0]       result;

  cfu_mac_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .act_base(act_base), .wgt_base(wgt_base),
    .input_offset(input_offset), .filter_offset(filter_offset), .fully(fully),
    .mem_rd_en(mem_rd_en), .act_addr(act_addr), .wgt_addr(wgt_addr),
    .act_rdata(act_rdata), .wgt_rdata(wgt_rdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_payload_function_id(cmd_payload_function_id),
    .cmd_payload_inputs_0(cmd_payload_inputs_0),
    .cmd_payload_inputs_1(cmd_payload_inputs_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_payload_outputs_0(rsp_payload_outputs_0),
    .busy(busy), .done(done), .result(result)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [9:0] fid; logic [31:0] in0; logic [31:0] in1; } cmd_t;
  typedef struct { logic [9:0] a; logic [9:0] w; } addr_t;
  typedef struct { logic [31:0] res; int cyc; } done_t;

  cmd_t  exp_cmd[$];
  addr_t exp_addr[$];
  done_t exp_done[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_acc    = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [31:0] sx9(input logic [8:0] v);
    return {{23{v[8]}}, v};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Operand memories: one-cycle read latency, garbage when not reading.
  logic [31:0] act_mem [1024];
  logic [31:0] wgt_mem [1024];
  logic        rd_pend = 1'b0;
  logic [9:0]  ra = '0, wa = '0;

  initial forever begin
    @(negedge clk);
    if (rd_pend) begin
      act_rdata = act_mem[ra];
      wgt_rdata = wgt_mem[wa];
    end else begin
      act_rdata = 32'hDEADBEEF;
      wgt_rdata = 32'hDEADBEEF;
    end
    rd_pend = mem_rd_en;
    ra      = act_addr;
    wa      = wgt_addr;
  end

  // CFU responder model with programmable accept stall and response delay.
  int          cmd_stall = 0, rsp_delay = 0;
  int          phase = 0, stall_cnt = 0, dly_cnt = 0;
  int          acc = 0, ioff = 0, foff = 0;
  logic        cf = 1'b0, rf = 1'b0;
  logic [9:0]  cap_fid;
  logic [31:0] cap_in0, cap_in1, rsp_val;

  initial begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_payload_outputs_0 = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_payload_outputs_0 = '0;
        phase = 0; stall_cnt = 0; cf = 1'b0; rf = 1'b0; acc = 0;
      end else begin
        if (rf) begin
          rsp_valid = 1'b0;
          phase = 0;
        end
        if (cf) begin
          case (cap_fid[9:3])
            7'd2: begin ioff = $signed(cap_in0); foff = $signed(cap_in1); end
            7'd1: acc = 0;
            7'd0, 7'd3: begin
              for (int b = 0; b < 4; b++)
                acc += (int'($signed(cap_in0[8*b +: 8])) + ioff) *
                       (int'($signed(cap_in1[8*b +: 8])) + foff);
            end
            default: acc = 32'h0BAD0BAD;
          endcase
          rsp_val = acc;
          phase = 1;
          dly_cnt = rsp_delay;
        end
        if (phase == 1) begin
          if (dly_cnt == 0) begin
            rsp_valid = 1'b1;
            rsp_payload_outputs_0 = rsp_val;
            phase = 2;
          end else begin
            dly_cnt--;
          end
        end
        cmd_ready = 1'b0;
        if (cmd_valid && phase == 0) begin
          if (stall_cnt < cmd_stall) stall_cnt++;
          else begin
            cmd_ready = 1'b1;
            stall_cnt = 0;
          end
        end
        cf = cmd_valid && cmd_ready;
        if (cf) begin
          cap_fid = cmd_payload_function_id;
          cap_in0 = cmd_payload_inputs_0;
          cap_in1 = cmd_payload_inputs_1;
        end
        rf = rsp_valid && rsp_ready;
      end
    end
  end

  // Monitor: drains the expectation queues as the DUT produces events.
  logic        prev_stalled = 1'b0;
  logic [9:0]  prev_fid;
  logic [31:0] prev_in0, prev_in1;

  initial forever begin
    @(negedge clk);
    #1;
    if (reset) begin
      prev_stalled = 1'b0;
    end else begin
      if (prev_stalled && cmd_valid) begin
        check("stall_fid", 32'(cmd_payload_function_id), 32'(prev_fid));
        check("stall_in0", cmd_payload_inputs_0, prev_in0);
        check("stall_in1", cmd_payload_inputs_1, prev_in1);
      end
      prev_stalled = cmd_valid && !cmd_ready;
      prev_fid = cmd_payload_function_id;
      prev_in0 = cmd_payload_inputs_0;
      prev_in1 = cmd_payload_inputs_1;
      if (cmd_valid && cmd_ready) begin
        n_acc++;
        if (exp_cmd.size() == 0) fail_now("unexpected_cmd");
        else begin
          cmd_t e;
          e = exp_cmd.pop_front();
          check("cmd_fid", 32'(cmd_payload_function_id), 32'(e.fid));
          check("cmd_in0", cmd_payload_inputs_0, e.in0);
          check("cmd_in1", cmd_payload_inputs_1, e.in1);
        end
      end
      if (mem_rd_en) begin
        if (exp_addr.size() == 0) fail_now("unexpected_mem_rd_en");
        else begin
          addr_t e;
          e = exp_addr.pop_front();
          check("act_addr", 32'(act_addr), 32'(e.a));
          check("wgt_addr", 32'(wgt_addr), 32'(e.w));
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_done.size() == 0) fail_now("unexpected_done");
        else begin
          done_t e;
          e = exp_done.pop_front();
          check("result", result, e.res);
          check("done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic kick(input int n, input int ab, input int wb, input logic [8:0] io,
                      input logic [8:0] fo, input logic f, input logic [31:0] exp_res,
                      input int exp_lat, input logic want_done);
    int a, w;
    exp_cmd.push_back('{10'h010, sx9(io), sx9(fo)});
    exp_cmd.push_back('{10'h008, 32'h0, 32'h0});
    for (int i = 0; i < n; i++) begin
      a = (ab + i) % 1024;
      w = (wb + i) % 1024;
      exp_cmd.push_back('{(f ? 10'h018 : 10'h000), act_mem[a], wgt_mem[w]});
      exp_addr.push_back('{a[9:0], w[9:0]});
    end
    @(negedge clk);
    len = LEN_W'(n); act_base = ADDR_W'(ab); wgt_base = ADDR_W'(wb);
    input_offset = io; filter_offset = fo; fully = f;
    start = 1'b1;
    if (want_done) exp_done.push_back('{exp_res, cyc + exp_lat});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #2;
      if (done_cnt >= target) return;
    end
    fail_now({"timeout_", name});
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      act_mem[i] = 32'h0;
      wgt_mem[i] = 32'h0;
    end
    act_mem[10'h020] = 32'h01010101; wgt_mem[10'h040] = 32'h02020202;
    act_mem[10'h100] = 32'h7F7F7F7F; act_mem[10'h101] = 32'h7F7F7F7F;
    wgt_mem[10'h200] = 32'h81818181; wgt_mem[10'h201] = 32'h81818181;
    act_mem[10'h3FF] = 32'h00000000; act_mem[10'h000] = 32'h01FF0080;
    wgt_mem[10'h010] = 32'h02020202; wgt_mem[10'h011] = 32'h03030303;

    reset = 1'b1; start = 1'b0; len = '0; act_base = '0; wgt_base = '0;
    input_offset = '0; filter_offset = '0; fully = 1'b0;
    #12;
    check("rst_cmd_valid", 32'(cmd_valid), 32'h0);
    check("rst_rsp_ready", 32'(rsp_ready), 32'h0);
    check("rst_mem_rd_en", 32'(mem_rd_en), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_fid", 32'(cmd_payload_function_id), 32'h0);
    check("rst_in0", cmd_payload_inputs_0, 32'h0);
    check("rst_in1", cmd_payload_inputs_1, 32'h0);
    check("rst_act_addr", 32'(act_addr), 32'h0);
    check("rst_wgt_addr", 32'(wgt_addr), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // len=1 basic ADD
    kick(1, 10'h020, 10'h040, 9'h000, 9'h000, 1'b0, 32'd8, 9, 1'b1);
    wait_done(1, "len1");
    repeat (2) @(negedge clk);

    // len=2 signed extremes
    kick(2, 10'h100, 10'h200, 9'h000, 9'h000, 1'b0, 32'hFFFE07F8, 13, 1'b1);
    wait_done(2, "len2");
    repeat (2) @(negedge clk);

    // same run with accept stalls of 3 and response delay of 2 on 4 commands
    cmd_stall = 3; rsp_delay = 2;
    kick(2, 10'h100, 10'h200, 9'h000, 9'h000, 1'b0, 32'hFFFE07F8, 13 + 5 * 4, 1'b1);
    wait_done(3, "stall");
    cmd_stall = 0; rsp_delay = 0;
    repeat (2) @(negedge clk);

    // len=0: configuration only
    kick(0, 10'h100, 10'h200, 9'h000, 9'h000, 1'b0, 32'h0, 5, 1'b1);
    wait_done(4, "len0");
    repeat (2) @(negedge clk);

    // reset while waiting on the second MAC response of a len=4 run
    n_acc = 0;
    kick(4, 10'h100, 10'h200, 9'h000, 9'h000, 1'b0, 32'h0, 0, 1'b0);
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
        @(negedge clk);
        #2;
        if (n_acc >= 4 && rsp_ready) hit = 1'b1;
      end
      if (!hit) fail_now("timeout_mac_rsp");
    end
    reset = 1'b1;
    #1;
    check("abort_cmd_valid", 32'(cmd_valid), 32'h0);
    check("abort_rsp_ready", 32'(rsp_ready), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_result", result, 32'h0);
    check("abort_fid", 32'(cmd_payload_function_id), 32'h0);
    check("abort_in0", cmd_payload_inputs_0, 32'h0);
    check("abort_act_addr", 32'(act_addr), 32'h0);
    check("abort_cmds_left", 32'(exp_cmd.size()), 32'd2);
    check("abort_reads_left", 32'(exp_addr.size()), 32'd2);
    exp_cmd.delete();
    exp_addr.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    kick(1, 10'h020, 10'h040, 9'h000, 9'h000, 1'b0, 32'd8, 9, 1'b1);
    wait_done(5, "after_reset");
    repeat (2) @(negedge clk);

    // FULLY with offsets, wrapping activation address, and a start while busy
    kick(2, 10'h3FF, 10'h010, 9'h080, 9'h1FF, 1'b1, 32'h00000500, 13, 1'b1);
    @(negedge clk);
    len = LEN_W'(5); act_base = '0; wgt_base = '0; fully = 1'b0;
    input_offset = '0; filter_offset = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, "busy_start");
    repeat (12) @(negedge clk);

    check("final_cmd_queue", 32'(exp_cmd.size()), 32'h0);
    check("final_addr_queue", 32'(exp_addr.size()), 32'h0);
    check("final_done_queue", 32'(exp_done.size()), 32'h0);
    check("final_idle", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
